// File: rtl/dog_stack_pipe.sv
// Difference-of-Gaussians engine for one octave: streams LEVELS blurred images,
// writes LEVELS-1 signed DoG images and tracks the peak |DoG| of each output level.
module dog_stack_pipe #(
    parameter  int PIX_W    = 8,
    parameter  int WIDTH    = 64,
    parameter  int HEIGHT   = 64,
    parameter  int LEVELS   = 3,
    parameter  int READ_LAT = 2,
    localparam int N        = WIDTH * HEIGHT,
    localparam int ADDR_W   = $clog2(N),
    localparam int DW       = PIX_W + 1,
    localparam int OUTS     = LEVELS - 1
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic                   start,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [LEVELS*PIX_W-1:0] rd_pix,
    output logic                   wea,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [OUTS*DW-1:0]     wr_data,
    output logic [OUTS*PIX_W-1:0]  max_abs,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_rd_en;
    logic                    r_wea;
    logic                    r_busy;
    logic                    r_done;
    logic [ADDR_W-1:0]       r_rd_addr;
    logic [ADDR_W-1:0]       r_wr_addr;
    logic [ADDR_W-1:0]       r_wcnt;
    logic [OUTS*DW-1:0]      r_wr_data;
    logic [OUTS*PIX_W-1:0]   r_max;
    logic [READ_LAT-1:0]     r_vld;
    logic [OUTS*DW-1:0]      w_diff;
    logic [OUTS*PIX_W-1:0]   w_abs;
    logic                    w_accept;
    logic                    w_last_rd;
    logic                    w_last_wr;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_last_rd = (r_rd_addr == ADDR_W'(N - 1));
    assign w_last_wr = r_wea && (r_wr_addr == ADDR_W'(N - 1));

    // Zero-extended subtraction cannot overflow; |DoG| always fits in PIX_W bits.
    always_comb begin
        w_diff = '0;
        w_abs  = '0;
        for (int k = 0; k < OUTS; k++) begin
            w_diff[k*DW +: DW] = {1'b0, rd_pix[k*PIX_W +: PIX_W]}
                               - {1'b0, rd_pix[(k+1)*PIX_W +: PIX_W]};
            w_abs[k*PIX_W +: PIX_W] = r_wr_data[k*DW + PIX_W]
                                    ? PIX_W'(-r_wr_data[k*DW +: DW])
                                    : r_wr_data[k*DW +: PIX_W];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)     w_next = S_READ;
            S_READ:  if (w_last_rd) w_next = S_DRAIN;
            S_DRAIN: if (w_last_wr) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_vld     <= '0;
            r_wea     <= 1'b0;
            r_wr_addr <= '0;
            r_wcnt    <= '0;
            r_wr_data <= '0;
            r_max     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_busy    <= 1'b1;
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= '0;
                    r_wcnt    <= '0;
                end
                S_READ: begin
                    if (w_last_rd) r_rd_en   <= 1'b0;
                    else           r_rd_addr <= r_rd_addr + 1'b1;
                end
                S_DRAIN: if (w_last_wr) begin
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_rd_addr <= '0;
                end
                default: ;
            endcase

            // Issue valids travel alongside the BRAM read latency.
            r_vld[0] <= r_rd_en;
            for (int i = 1; i < READ_LAT; i++) r_vld[i] <= r_vld[i-1];

            r_wea <= r_vld[READ_LAT-1];
            if (r_vld[READ_LAT-1]) begin
                r_wr_data <= w_diff;
                r_wr_addr <= r_wcnt;
                r_wcnt    <= r_wcnt + 1'b1;
            end

            if (r_wea) begin
                for (int k = 0; k < OUTS; k++) begin
                    if (w_abs[k*PIX_W +: PIX_W] > r_max[k*PIX_W +: PIX_W])
                        r_max[k*PIX_W +: PIX_W] <= w_abs[k*PIX_W +: PIX_W];
                end
            end
            if (w_accept) r_max <= '0;
        end
    end

    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;
    assign wea     = r_wea;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign max_abs = r_max;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_dog_stack_pipe.sv
// Directed bench for dog_stack_pipe: N=8 image, three levels, read latency 2
// plus a read-latency-1 instance sharing start, reset and image data.
module tb_dog_stack_pipe;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        start;

    logic        rd_en,  rd_en1;
    logic [2:0]  rd_addr, rd_addr1;
    logic [23:0] rd_pix, rd_pix1;
    logic        wea, wea1;
    logic [2:0]  wr_addr, wr_addr1;
    logic [17:0] wr_data, wr_data1;
    logic [15:0] max_abs, max_abs1;
    logic        busy, busy1, done, done1;

    logic [7:0]  g0 [0:7];
    logic [7:0]  g1 [0:7];
    logic [7:0]  g2 [0:7];
    logic [8:0]  e0 [0:7];
    logic [8:0]  e1 [0:7];
    logic [7:0]  em0, em1;
    logic [23:0] p1, p2, q1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dog_stack_pipe #(.PIX_W(8), .WIDTH(4), .HEIGHT(2), .LEVELS(3), .READ_LAT(2)) dut (
        .clk(clk), .rst_in(rst_in), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_pix(rd_pix),
        .wea(wea), .wr_addr(wr_addr), .wr_data(wr_data),
        .max_abs(max_abs), .busy(busy), .done(done)
    );

    dog_stack_pipe #(.PIX_W(8), .WIDTH(4), .HEIGHT(2), .LEVELS(3), .READ_LAT(1)) dut1 (
        .clk(clk), .rst_in(rst_in), .start(start),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_pix(rd_pix1),
        .wea(wea1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .max_abs(max_abs1), .busy(busy1), .done(done1)
    );

    // Behavioural BRAMs: two register stages for dut, one for dut1.
    always @(posedge clk) begin
        p1 <= {g2[rd_addr], g1[rd_addr], g0[rd_addr]};
        p2 <= p1;
        q1 <= {g2[rd_addr1], g1[rd_addr1], g0[rd_addr1]};
    end
    assign rd_pix  = p2;
    assign rd_pix1 = q1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic load_ramp();
        for (int a = 0; a < 8; a++) begin
            g0[a] = 8'(10*a); g1[a] = 8'(5*a); g2[a] = 8'(a);
            e0[a] = 9'(5*a);  e1[a] = 9'(4*a);
        end
        em0 = 8'd35; em1 = 8'd28;
    endtask

    task automatic load_neg();
        for (int a = 0; a < 8; a++) begin
            g0[a] = 8'd0; g1[a] = 8'd255; g2[a] = 8'd0;
            e0[a] = 9'h101; e1[a] = 9'h0FF;
        end
        em0 = 8'd255; em1 = 8'd255;
    endtask

    // slice0 = +3, slice1 = -2 everywhere
    task automatic load_small();
        for (int a = 0; a < 8; a++) begin
            g0[a] = 8'(a+3); g1[a] = 8'(a); g2[a] = 8'(a+2);
            e0[a] = 9'h003; e1[a] = 9'h1FE;
        end
        em0 = 8'd3; em1 = 8'd2;
    endtask

    // Checks every output during cycle c of a pass (cycle 0 follows the start edge).
    task automatic chk_cycle(input int c, input int lat);
        logic        ren, we, bsy, dn;
        logic [2:0]  ra, wa;
        logic [17:0] wd;
        logic [15:0] mx;
        bit          wexp;
        if (lat == 1) begin
            ren = rd_en1; ra = rd_addr1; we = wea1; wa = wr_addr1;
            wd = wr_data1; mx = max_abs1; bsy = busy1; dn = done1;
        end else begin
            ren = rd_en; ra = rd_addr; we = wea; wa = wr_addr;
            wd = wr_data; mx = max_abs; bsy = busy; dn = done;
        end
        wexp = (c >= lat + 1) && (c <= 8 + lat);
        check("rd_en", 64'(ren), 64'(c < 8));
        check("rd_addr", 64'(ra), 64'(c < 8 ? c : (c <= 8 + lat ? 7 : 0)));
        check("wea", 64'(we), 64'(wexp));
        if (wexp) begin
            check("wr_addr", 64'(wa), 64'(c - lat - 1));
            check("wr_data", 64'(wd), 64'({e1[c-lat-1], e0[c-lat-1]}));
        end
        check("busy", 64'(bsy), 64'(c <= 8 + lat));
        check("done", 64'(dn), 64'(c == 9 + lat));
        if (c == 0)       check("max_clear", 64'(mx), 64'd0);
        if (c == 9 + lat) check("max_abs", 64'(mx), 64'({em1, em0}));
    endtask

    task automatic run_pass(input int lat, input bit repulse);
        int n_we = 0;
        int n_dn = 0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c <= 10 + lat; c++) begin
            @(negedge clk);
            if (repulse) start = (c == 2 || c == 9);
            chk_cycle(c, lat);
            if (lat == 1) begin n_we += int'(wea1); n_dn += int'(done1); end
            else          begin n_we += int'(wea);  n_dn += int'(done);  end
        end
        start = 1'b0;
        check("wea_count", 64'(n_we), 64'd8);
        check("done_count", 64'(n_dn), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_in = 1'b1;
        start  = 1'b0;
        load_ramp();
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({rd_en, rd_addr, wea, wr_addr, wr_data, max_abs, busy, done}), 64'd0);
        rst_in = 1'b0;
        @(negedge clk);

        // Ramp
        run_pass(2, 1'b0);

        // Negative extreme
        load_neg();
        run_pass(2, 1'b0);

        // Start while busy
        load_ramp();
        run_pass(2, 1'b1);

        // Back-to-back with start held high
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk_cycle(c, 2);
        end
        load_small();
        @(posedge clk); #1 start = 1'b0;
        for (int c = 12; c < 24; c++) begin
            if (c > 12) @(negedge clk);
            else        @(negedge clk);
            chk_cycle(c - 12, 2);
        end
        repeat (3) @(negedge clk);

        // Async reset mid-pass
        load_ramp();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            chk_cycle(c, 2);
        end
        #1 rst_in = 1'b1;
        #1 check("async_reset", 64'({rd_en, rd_addr, wea, wr_addr, wr_data, max_abs, busy, done}), 64'd0);
        repeat (2) @(negedge clk);
        check("reset_held", 64'({rd_en, rd_addr, wea, busy, done}), 64'd0);
        rst_in = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("no_done_after_reset", 64'({busy, done, wea}), 64'd0);
        end
        run_pass(2, 1'b0);

        // Read latency 1
        run_pass(1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dog_stack_pipe.md
Name: dog_stack_pipe

Overview:
- Parametrised, pipelined difference-of-Gaussians engine for one octave.
- Reads LEVELS blurred images of the octave in parallel over a shared read address, one pixel per cycle.
- Writes LEVELS-1 signed DoG images through a shared write port.
- Tracks the peak |DoG| per output level; downstream keypoint thresholding reads these values after done.

Parameters:
- PIX_W, 8: unsigned Gaussian pixel width.
- WIDTH, 64: image width in pixels; non-square images allowed.
- HEIGHT, 64: image height in pixels.
- LEVELS, 3: number of Gaussian inputs, minimum 2; produces LEVELS-1 DoG outputs.
- READ_LAT, 2: BRAM read latency in cycles, from rd_addr presented to rd_pix valid; minimum 1.
- Derived localparams: N = WIDTH*HEIGHT; ADDR_W = $clog2(N).

Ports:
- clk  in  1  system clock.
- rst_in  in  1  asynchronous, active-high reset.
- start  in  1  begin one pass; sampled only in IDLE.
- rd_en  out  1  read enable to all Gaussian BRAMs.
- rd_addr  out  ADDR_W  shared read address.
- rd_pix  in  LEVELS*PIX_W  packed pixels; level 0 (sharpest) in the LSBs.
- wea  out  1  write enable to all DoG BRAMs.
- wr_addr  out  ADDR_W  shared write address.
- wr_data  out  (LEVELS-1)*(PIX_W+1)  packed signed DoG values; slice k = level k minus level k+1.
- max_abs  out  (LEVELS-1)*PIX_W  packed peak |DoG| per output level.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at end of pass.

Behaviour:
- Reset: asynchronous and active-high. Every output goes to 0 immediately, state goes to IDLE, and the valid pipeline clears. There is no done pulse on reset. Reset mid-pass abandons the pass; the DoG BRAM keeps whatever was already written.
- States: IDLE, READ, DRAIN.
- IDLE -> READ: on a clock edge with start=1.
  - Call this edge E0; cycle c is the cycle following edge E0+c.
  - At E0: busy<=1, rd_en<=1, rd_addr<=0, max_abs<=0.
- READ:
  - rd_addr=k and rd_en=1 during cycle k, for k = 0..N-1.
  - After address N-1 is issued: rd_en<=0, state -> DRAIN.
  - rd_addr holds N-1 after the last issue and returns to 0 in IDLE.
- Valid pipeline: a READ_LAT-deep shift register of issue valids. rd_pix for address k is sampled at the end of cycle k+READ_LAT.
- Subtract stage: registered.
  - wea=1, wr_addr=k and wr_data=DoG(k) during cycle k+READ_LAT+1.
  - wea is high for exactly N consecutive cycles per pass. Throughput is 1 pixel/cycle with no bubbles.
- Arithmetic:
  - Each pixel is zero-extended to PIX_W+1 bits before subtraction.
  - The difference range is [-(2^PIX_W-1), 2^PIX_W-1]; it never overflows or saturates.
  - |DoG| fits in PIX_W bits.
- max_abs[k]:
  - Updated with max(max_abs[k], |DoG_k|) on each write cycle.
  - Cleared only at start acceptance or reset.
  - Stable from the done cycle until the next accepted start.
- DRAIN: after the final write (cycle N+READ_LAT):
  - Cycle N+READ_LAT+1: busy=0, done=1 for exactly one cycle, state = IDLE.
  - wea is 0 from this cycle onward.
- start while busy (READ or DRAIN): ignored, with no effect on addresses or counts.
- start high during the done cycle: accepted on the next edge, because state is already IDLE; the new pass begins back-to-back.
- start held high continuously: passes repeat back-to-back, each exactly N+READ_LAT+2 cycles from E0 to E0.
- wr_data holds its last value when wea=0. Consumers qualify on wea only.

Test Plan (PIX_W=8, WIDTH=4, HEIGHT=2 so N=8, LEVELS=3, READ_LAT=2, behavioural BRAM model):
- Ramp: level0=10a, level1=5a, level2=a at address a; pulse start.
  - Expect writes at cycles 3..10 with wr_addr=0..7.
  - Slice0=5a, slice1=4a.
  - done=1 at cycle 11 only; max_abs={28,35}.
- Negative extreme: level0=0, level1=255, level2=0 everywhere.
  - Expect slice0=9'h101 (-255) and slice1=9'h0FF (+255) at every address.
  - max_abs={255,255}.
- Start while busy: re-pulse start at cycles 2 and 9.
  - Expect exactly 8 wea pulses and one done.
  - rd_addr sequence is unbroken 0..7.
- Back-to-back: hold start high across two passes with different data.
  - Second pass rd_addr=0 at cycle 12.
  - max_abs is cleared at the second E0, then reflects only second-pass data.
- Async reset: assert rst_in between clock edges at cycle 5 (rd_addr=5).
  - Expect all outputs 0 before the next edge, and no done.
  - A later start restarts from address 0 with correct timing.
- Latency variant: rebuild with READ_LAT=1 and run the ramp.
  - Expect writes at cycles 2..9 and done at cycle 10.
